// File: rtl/raycast_pkg.sv
// Shared constants, FSM state type and wrap-around angle helpers for the ray-casting pipeline.
// Angles are fixed point: integer degrees * 1024 + fraction.
package raycast_pkg;

   localparam int          ANGLE_FULL_FIXED = 368640;
   localparam int          FRAC_BITS        = 10;
   localparam int          MAZE_MAX         = 4096;
   localparam logic        SIDE_HORIZ       = 1'b0;
   localparam logic        SIDE_VERT        = 1'b1;
   localparam logic [26:0] DIST_MISS        = 27'h7FFFFFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_HITS,
      S_DIST,
      S_SELECT,
      S_OUTPUT,
      S_ADVANCE
   } seq_state_t;

   // Both operands are already below one full turn, so one correction suffices.
   function automatic logic [19:0] angle_add_wrap(input logic [19:0] a, input logic [19:0] b);
      logic [19:0] s;
      s = a + b;
      if (s >= 20'(ANGLE_FULL_FIXED))
         s = s - 20'(ANGLE_FULL_FIXED);
      return s;
   endfunction

   function automatic logic [19:0] angle_sub_wrap(input logic [19:0] a, input logic [19:0] b);
      if (a < b)
         return a + (20'(ANGLE_FULL_FIXED) - b);
      return a - b;
   endfunction

endpackage

// File: rtl/ray_dist_sq.sv
// Combinational squared Euclidean distance between a wall hit and the ray origin.
// Differences are 14-bit signed, so each square fits in 26 bits and the sum in 27.
module ray_dist_sq (
   input  logic signed [12:0] wall_x,
   input  logic signed [12:0] wall_y,
   input  logic signed [12:0] org_x,
   input  logic signed [12:0] org_y,
   output logic        [26:0] dist_sq
);

   logic signed [13:0] dx;
   logic signed [13:0] dy;
   logic        [13:0] adx;
   logic        [13:0] ady;
   logic        [25:0] adx_w;
   logic        [25:0] ady_w;
   logic        [25:0] sq_x;
   logic        [25:0] sq_y;

   assign dx = $signed({wall_x[12], wall_x}) - $signed({org_x[12], org_x});
   assign dy = $signed({wall_y[12], wall_y}) - $signed({org_y[12], org_y});

   // |d| never exceeds 8191, so the negation cannot overflow 14 bits.
   assign adx = dx[13] ? $unsigned(-dx) : $unsigned(dx);
   assign ady = dy[13] ? $unsigned(-dy) : $unsigned(dy);

   assign adx_w = {12'd0, adx};
   assign ady_w = {12'd0, ady};
   assign sq_x  = adx_w * adx_w;
   assign sq_y  = ady_w * ady_w;

   assign dist_sq = {1'b0, sq_x} + {1'b0, sq_y};

endmodule

// File: rtl/ray_column_sequencer.sv
// Per-frame ray dispatcher: sweeps the field of view, launches both wall finders per ray,
// keeps the nearer hit and hands one column record per ray to the renderer.
module ray_column_sequencer
   import raycast_pkg::*;
#(
   parameter int NUM_COLS        = 160,
   parameter int COL_W           = 8,
   parameter int HALF_FOV_DEG    = 30,
   parameter int ANGLE_STEP_FRAC = 384,
   parameter int MAX_WAIT        = 4095
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    start_frame,
   input  logic signed [12:0]      player_x,
   input  logic signed [12:0]      player_y,
   input  logic        [9:0]       player_ang_int,
   input  logic        [9:0]       player_ang_frac,
   output logic        [9:0]       alpha_X,
   output logic        [9:0]       alpha_Y,
   output logic signed [12:0]      ray_x,
   output logic signed [12:0]      ray_y,
   output logic                    begin_calc,
   input  logic                    h_end_calc,
   input  logic                    h_wall_found,
   input  logic signed [12:0]      h_wall_x,
   input  logic signed [12:0]      h_wall_y,
   input  logic                    v_end_calc,
   input  logic                    v_wall_found,
   input  logic signed [12:0]      v_wall_x,
   input  logic signed [12:0]      v_wall_y,
   output logic                    col_valid,
   input  logic                    col_ready,
   output logic        [COL_W-1:0] col_idx,
   output logic                    col_hit,
   output logic                    col_side,
   output logic        [26:0]      col_dist_sq,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int               WAIT_W         = $clog2(MAX_WAIT + 1);
   localparam logic [19:0]      HALF_FOV_FIXED = 20'(HALF_FOV_DEG << FRAC_BITS);
   localparam logic [19:0]      STEP_FIXED     = 20'(ANGLE_STEP_FRAC);
   localparam logic [COL_W-1:0] LAST_COL       = COL_W'(NUM_COLS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT    = WAIT_W'(MAX_WAIT);

   seq_state_t         state_reg;
   // Top bit is always zero (angle < 360*1024); keeping it lets alpha_X map straight out.
   logic [19:0]        angle_reg;
   logic [WAIT_W-1:0]  wait_cnt_reg;
   logic [WAIT_W-1:0]  wait_cnt_next;
   logic               h_done_reg;
   logic               v_done_reg;
   logic               h_found_reg;
   logic               v_found_reg;
   logic signed [12:0] h_x_reg;
   logic signed [12:0] h_y_reg;
   logic signed [12:0] v_x_reg;
   logic signed [12:0] v_y_reg;
   logic [26:0]        h_dsq;
   logic [26:0]        v_dsq;
   logic [26:0]        h_dsq_reg;
   logic [26:0]        v_dsq_reg;

   assign alpha_X       = angle_reg[19:10];
   assign alpha_Y       = angle_reg[9:0];
   assign wait_cnt_next = wait_cnt_reg + WAIT_W'(1);

   ray_dist_sq u_h_dist (
      .wall_x  (h_x_reg),
      .wall_y  (h_y_reg),
      .org_x   (ray_x),
      .org_y   (ray_y),
      .dist_sq (h_dsq)
   );

   ray_dist_sq u_v_dist (
      .wall_x  (v_x_reg),
      .wall_y  (v_y_reg),
      .org_x   (ray_x),
      .org_y   (ray_y),
      .dist_sq (v_dsq)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_reg    <= S_IDLE;
         angle_reg    <= '0;
         wait_cnt_reg <= '0;
         h_done_reg   <= 1'b0;
         v_done_reg   <= 1'b0;
         h_found_reg  <= 1'b0;
         v_found_reg  <= 1'b0;
         h_x_reg      <= '0;
         h_y_reg      <= '0;
         v_x_reg      <= '0;
         v_y_reg      <= '0;
         h_dsq_reg    <= '0;
         v_dsq_reg    <= '0;
         ray_x        <= '0;
         ray_y        <= '0;
         begin_calc   <= 1'b0;
         col_valid    <= 1'b0;
         col_idx      <= '0;
         col_hit      <= 1'b0;
         col_side     <= SIDE_HORIZ;
         col_dist_sq  <= DIST_MISS;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         begin_calc <= 1'b0;
         frame_done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start_frame) begin
                  ray_x      <= player_x;
                  ray_y      <= player_y;
                  angle_reg  <= angle_add_wrap({player_ang_int, player_ang_frac}, HALF_FOV_FIXED);
                  col_idx    <= '0;
                  busy       <= 1'b1;
                  begin_calc <= 1'b1;
                  state_reg  <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               // Clearing found here makes a side that never reports read as a miss.
               h_done_reg   <= 1'b0;
               v_done_reg   <= 1'b0;
               h_found_reg  <= 1'b0;
               v_found_reg  <= 1'b0;
               wait_cnt_reg <= '0;
               state_reg    <= S_WAIT_HITS;
            end
            S_WAIT_HITS: begin
               wait_cnt_reg <= wait_cnt_next;
               if (h_end_calc && !h_done_reg) begin
                  h_done_reg  <= 1'b1;
                  h_found_reg <= h_wall_found;
                  h_x_reg     <= h_wall_x;
                  h_y_reg     <= h_wall_y;
               end
               if (v_end_calc && !v_done_reg) begin
                  v_done_reg  <= 1'b1;
                  v_found_reg <= v_wall_found;
                  v_x_reg     <= v_wall_x;
                  v_y_reg     <= v_wall_y;
               end
               if (((h_done_reg || h_end_calc) && (v_done_reg || v_end_calc)) ||
                   (wait_cnt_next == WAIT_LIMIT))
                  state_reg <= S_DIST;
            end
            S_DIST: begin
               h_dsq_reg <= h_dsq;
               v_dsq_reg <= v_dsq;
               state_reg <= S_SELECT;
            end
            S_SELECT: begin
               if (h_found_reg && v_found_reg) begin
                  col_hit <= 1'b1;
                  // Equal distances favour the horizontal grid line.
                  if (v_dsq_reg < h_dsq_reg) begin
                     col_side    <= SIDE_VERT;
                     col_dist_sq <= v_dsq_reg;
                  end else begin
                     col_side    <= SIDE_HORIZ;
                     col_dist_sq <= h_dsq_reg;
                  end
               end else if (h_found_reg) begin
                  col_hit     <= 1'b1;
                  col_side    <= SIDE_HORIZ;
                  col_dist_sq <= h_dsq_reg;
               end else if (v_found_reg) begin
                  col_hit     <= 1'b1;
                  col_side    <= SIDE_VERT;
                  col_dist_sq <= v_dsq_reg;
               end else begin
                  col_hit     <= 1'b0;
                  col_side    <= SIDE_HORIZ;
                  col_dist_sq <= DIST_MISS;
               end
               col_valid <= 1'b1;
               state_reg <= S_OUTPUT;
            end
            S_OUTPUT: begin
               if (col_ready) begin
                  col_valid <= 1'b0;
                  state_reg <= S_ADVANCE;
               end
            end
            S_ADVANCE: begin
               if (col_idx == LAST_COL) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state_reg  <= S_IDLE;
               end else begin
                  col_idx    <= col_idx + COL_W'(1);
                  angle_reg  <= angle_sub_wrap(angle_reg, STEP_FIXED);
                  begin_calc <= 1'b1;
                  state_reg  <= S_LAUNCH;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_column_sequencer.sv
// Self-checking bench: emulates both wall finders per column and checks every column
// record against a reference computed from the angle/distance rules with plain integer math.
module tb_ray_column_sequencer;
   import raycast_pkg::*;

   localparam int NCOL = 160;
   localparam int TMO  = 15;
   localparam int STEP = 384;
   localparam int MISS = 134217727;

   logic               clock = 1'b0;
   logic               resetn = 1'b0;
   logic               start_frame = 1'b0;
   logic signed [12:0] player_x = '0;
   logic signed [12:0] player_y = '0;
   logic        [9:0]  player_ang_int = '0;
   logic        [9:0]  player_ang_frac = '0;
   logic        [9:0]  alpha_X;
   logic        [9:0]  alpha_Y;
   logic signed [12:0] ray_x;
   logic signed [12:0] ray_y;
   logic               begin_calc;
   logic               h_end_calc = 1'b0;
   logic               h_wall_found = 1'b0;
   logic signed [12:0] h_wall_x = '0;
   logic signed [12:0] h_wall_y = '0;
   logic               v_end_calc = 1'b0;
   logic               v_wall_found = 1'b0;
   logic signed [12:0] v_wall_x = '0;
   logic signed [12:0] v_wall_y = '0;
   logic               col_valid;
   logic               col_ready = 1'b1;
   logic        [7:0]  col_idx;
   logic               col_hit;
   logic               col_side;
   logic        [26:0] col_dist_sq;
   logic               busy;
   logic               frame_done;

   int n_checks = 0;
   int n_fail   = 0;
   int fd_cnt   = 0;
   int bc_cnt   = 0;
   int m_angle, m_px, m_py;
   int exp_frames = 0;
   int exp_launches = 0;

   ray_column_sequencer #(
      .NUM_COLS        (NCOL),
      .COL_W           (8),
      .HALF_FOV_DEG    (30),
      .ANGLE_STEP_FRAC (STEP),
      .MAX_WAIT        (TMO)
   ) dut (
      .clock           (clock),
      .resetn          (resetn),
      .start_frame     (start_frame),
      .player_x        (player_x),
      .player_y        (player_y),
      .player_ang_int  (player_ang_int),
      .player_ang_frac (player_ang_frac),
      .alpha_X         (alpha_X),
      .alpha_Y         (alpha_Y),
      .ray_x           (ray_x),
      .ray_y           (ray_y),
      .begin_calc      (begin_calc),
      .h_end_calc      (h_end_calc),
      .h_wall_found    (h_wall_found),
      .h_wall_x        (h_wall_x),
      .h_wall_y        (h_wall_y),
      .v_end_calc      (v_end_calc),
      .v_wall_found    (v_wall_found),
      .v_wall_x        (v_wall_x),
      .v_wall_y        (v_wall_y),
      .col_valid       (col_valid),
      .col_ready       (col_ready),
      .col_idx         (col_idx),
      .col_hit         (col_hit),
      .col_side        (col_side),
      .col_dist_sq     (col_dist_sq),
      .busy            (busy),
      .frame_done      (frame_done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (begin_calc) bc_cnt <= bc_cnt + 1;
   end

   task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s col %0d: observed %0d expected %0d", tag, c, obs, exp);
      end
   endtask

   task automatic check_reset(input int tag_id);
      check("rst_begin_calc", tag_id, 32'(begin_calc), 32'(0));
      check("rst_col_valid", tag_id, 32'(col_valid), 32'(0));
      check("rst_busy", tag_id, 32'(busy), 32'(0));
      check("rst_frame_done", tag_id, 32'(frame_done), 32'(0));
      check("rst_alpha_X", tag_id, 32'(alpha_X), 32'(0));
      check("rst_alpha_Y", tag_id, 32'(alpha_Y), 32'(0));
      check("rst_ray_x", tag_id, 32'(ray_x), 32'(0));
      check("rst_ray_y", tag_id, 32'(ray_y), 32'(0));
      check("rst_col_idx", tag_id, 32'(col_idx), 32'(0));
      check("rst_col_hit", tag_id, 32'(col_hit), 32'(0));
      check("rst_col_side", tag_id, 32'(col_side), 32'(0));
      check("rst_col_dist_sq", tag_id, 32'(col_dist_sq), 32'(MISS));
   endtask

   task automatic start_sweep(input int px, input int py, input int ai, input int af);
      @(negedge clock);
      player_x        = 13'(px);
      player_y        = 13'(py);
      player_ang_int  = 10'(ai);
      player_ang_frac = 10'(af);
      start_frame     = 1'b1;
      m_px    = px;
      m_py    = py;
      m_angle = (ai * 1024 + af + 30 * 1024) % ANGLE_FULL_FIXED;
   endtask

   // Latency <= 0 means that finder never reports end_calc for this ray.
   task automatic run_column(input int c,
                             input bit hf, input int hx, input int hy, input int hl,
                             input bit vf, input int vx, input int vy, input int vl,
                             input int rdelay, input bit poke);
      int  t, hd, vd, exp_hit, exp_side, exp_dist, exp_lat, extra_bc, found;
      bit  hfe, vfe;
      hfe = hf && (hl > 0);
      vfe = vf && (vl > 0);
      hd  = (hx - m_px) * (hx - m_px) + (hy - m_py) * (hy - m_py);
      vd  = (vx - m_px) * (vx - m_px) + (vy - m_py) * (vy - m_py);
      if (hfe && vfe) begin
         exp_hit  = 1;
         exp_side = (vd < hd) ? 1 : 0;
         exp_dist = exp_side ? vd : hd;
      end else if (hfe) begin
         exp_hit = 1; exp_side = 0; exp_dist = hd;
      end else if (vfe) begin
         exp_hit = 1; exp_side = 1; exp_dist = vd;
      end else begin
         exp_hit = 0; exp_side = 0; exp_dist = MISS;
      end
      exp_lat = (hl > 0 && vl > 0) ? (((hl > vl) ? hl : vl) + 3) : (TMO + 3);

      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
         @(negedge clock);
         start_frame = 1'b0;
         if (begin_calc) found = 1;
      end
      check("launch", c, 32'(found), 32'(1));
      check("alpha_X", c, 32'(alpha_X), 32'(m_angle / 1024));
      check("alpha_Y", c, 32'(alpha_Y), 32'(m_angle % 1024));
      check("busy", c, 32'(busy), 32'(1));
      col_ready = (rdelay == 0);

      found = 0; extra_bc = 0; t = 0;
      while (found == 0 && t < 60) begin
         @(negedge clock);
         t++;
         if (begin_calc) extra_bc++;
         if (poke && t == 1) begin
            start_frame    = 1'b1;
            player_x       = 13'(m_px + 7);
            player_ang_int = 10'd200;
         end else begin
            start_frame = 1'b0;
         end
         if (hl > 0 && t == hl) begin
            h_end_calc = 1'b1; h_wall_found = hf; h_wall_x = 13'(hx); h_wall_y = 13'(hy);
         end else begin
            h_end_calc = (hl > 0 && t > hl);
            h_wall_found = 1'($urandom); h_wall_x = 13'($urandom); h_wall_y = 13'($urandom);
         end
         if (vl > 0 && t == vl) begin
            v_end_calc = 1'b1; v_wall_found = vf; v_wall_x = 13'(vx); v_wall_y = 13'(vy);
         end else begin
            v_end_calc = (vl > 0 && t > vl);
            v_wall_found = 1'($urandom); v_wall_x = 13'($urandom); v_wall_y = 13'($urandom);
         end
         if (col_valid) found = 1;
      end
      h_end_calc = 1'b0;
      v_end_calc = 1'b0;
      check("col_valid", c, 32'(found), 32'(1));
      check("latency", c, 32'(t), 32'(exp_lat));
      check("col_idx", c, 32'(col_idx), 32'(c));
      check("col_hit", c, 32'(col_hit), 32'(exp_hit));
      check("col_side", c, 32'(col_side), 32'(exp_side));
      check("col_dist_sq", c, 32'(col_dist_sq), 32'(exp_dist));
      check("ray_x", c, 32'(ray_x), 32'(13'(m_px)));
      check("ray_y", c, 32'(ray_y), 32'(13'(m_py)));
      check("early_launch", c, 32'(extra_bc), 32'(0));

      for (int i = 0; i < rdelay; i++) begin
         @(negedge clock);
         check("hold_valid", c, 32'(col_valid), 32'(1));
         check("hold_dist", c, 32'(col_dist_sq), 32'(exp_dist));
         check("hold_side", c, 32'(col_side), 32'(exp_side));
         check("hold_idx", c, 32'(col_idx), 32'(c));
         check("hold_no_launch", c, 32'(begin_calc), 32'(0));
      end
      col_ready = 1'b1;
      @(negedge clock);
      check("accepted", c, 32'(col_valid), 32'(0));
      $display("col %0d alpha %0d.%0d hit %0b side %0b dist %0d lat %0d", c,
               m_angle / 1024, m_angle % 1024, col_hit, col_side, col_dist_sq, t);
      m_angle = (m_angle - STEP + ANGLE_FULL_FIXED) % ANGLE_FULL_FIXED;
   endtask

   task automatic random_column(input int c, input int rdelay, input bit poke);
      int hl, vl;
      hl = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 12));
      vl = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 12));
      run_column(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, MAZE_MAX - 1)),
                 int'($urandom_range(0, MAZE_MAX - 1)), hl,
                 1'($urandom_range(0, 1)), int'($urandom_range(0, MAZE_MAX - 1)),
                 int'($urandom_range(0, MAZE_MAX - 1)), vl, rdelay, poke);
   endtask

   task automatic run_frame(input int px, input int py, input int ai, input int af, input int abort_col);
      int found;
      start_sweep(px, py, ai, af);
      for (int c = 0; c < NCOL; c++) begin
         if (c == abort_col) begin
            found = 0;
            for (int i = 0; i < 50 && found == 0; i++) begin
               @(negedge clock);
               if (begin_calc) found = 1;
            end
            check("abort_launch", c, 32'(found), 32'(1));
            exp_launches += c + 1;
            repeat (3) @(negedge clock);
            resetn = 1'b0;
            @(negedge clock);
            check_reset(c);
            @(negedge clock);
            resetn = 1'b1;
            repeat (5) @(negedge clock);
            check("abort_no_frame_done", c, 32'(fd_cnt), 32'(exp_frames));
            check("abort_idle", c, 32'(busy), 32'(0));
            check("abort_launches", c, 32'(bc_cnt), 32'(exp_launches));
            return;
         end
         case (c)
            0: run_column(c, 1, px, py - 64, 3, 1, px + 64, py + 10, 5, 0, 0);
            1: run_column(c, 1, px + 64, py + 10, 4, 1, px, py - 64, 2, 0, 0);
            2: run_column(c, 1, px + 10, py + 64, 6, 1, px + 64, py + 10, 6, 0, 0);
            3: run_column(c, 0, px + 5, py + 5, 2, 0, px - 5, py - 5, 7, 0, 0);
            4: run_column(c, 1, px, py - 64, 4, 1, px + 3, py + 3, -1, 0, 0);
            5: random_column(c, 10, 0);
            6: run_column(c, 1, px + 3, py + 3, -1, 1, px - 20, py + 30, 5, 0, 0);
            8: random_column(c, 0, 1);
            default: random_column(c, (c % 37 == 0) ? 3 : 0, 0);
         endcase
      end
      exp_frames++;
      exp_launches += NCOL;
      @(negedge clock);
      check("frame_done", NCOL, 32'(frame_done), 32'(1));
      check("busy_end", NCOL, 32'(busy), 32'(0));
      @(negedge clock);
      check("frame_done_pulse", NCOL, 32'(frame_done), 32'(0));
      check("frame_count", NCOL, 32'(fd_cnt), 32'(exp_frames));
      check("launch_count", NCOL, 32'(bc_cnt), 32'(exp_launches));
   endtask

   initial begin
      resetn = 1'b0;
      repeat (3) @(negedge clock);
      check_reset(-1);
      resetn = 1'b1;
      @(negedge clock);

      run_frame(100, 100, 90, 0, -1);
      run_frame(2000, 1500, 10, 0, -1);
      run_frame(500, 3000, 340, 0, 37);
      run_frame(int'($urandom_range(100, 3995)), int'($urandom_range(100, 3995)),
                int'($urandom_range(0, 359)), int'($urandom_range(0, 1023)), -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ray_column_sequencer.md
Name: ray_column_sequencer

Overview:
- Per-frame ray dispatcher that sits directly upstream of find_wall_intersection_horiz and its vertical counterpart.
- Sweeps NUM_COLS ray angles across the field of view and launches both intersection finders in parallel for each ray.
- Collects both results and picks the nearer wall by squared Euclidean distance.
- Hands one column record per ray to the column renderer over a valid/ready handshake.

Parameters:
- NUM_COLS, 160, rays (screen columns) per frame.
- COL_W, 8, width of column index.
- HALF_FOV_DEG, 30, start angle offset (integer degrees) added to player angle.
- ANGLE_STEP_FRAC, 384, per-column angle decrement in 1/1024-degree units (0.375 deg).
- MAX_WAIT, 4095, cycle limit waiting for finders; on expiry, missing result treated as no hit.

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  synchronous, active-low reset
- start_frame  in  1  pulse: sample player state, begin sweep
- player_x, player_y  in  13 signed  player position
- player_ang_int  in  10  player angle, integer degrees 0..359
- player_ang_frac  in  10  player angle fraction, 1/1024 deg
- alpha_X  out  10  current ray angle, integer degrees 0..359
- alpha_Y  out  10  current ray angle fraction
- ray_x, ray_y  out  13 signed  latched player position, driven to finders' playerX/playerY
- begin_calc  out  1  one-cycle launch pulse to both finders
- h_end_calc, h_wall_found  in  1  horizontal finder status
- h_wall_x, h_wall_y  in  13 signed  horizontal hit
- v_end_calc, v_wall_found  in  1  vertical finder status
- v_wall_x, v_wall_y  in  13 signed  vertical hit
- col_valid  out  1  column record valid
- col_ready  in  1  renderer accepts record
- col_idx  out  COL_W  column number
- col_hit  out  1  a wall was found
- col_side  out  1  0 = horizontal grid line, 1 = vertical
- col_dist_sq  out  27  squared distance to selected hit
- busy  out  1  sweep in progress
- frame_done  out  1  one-cycle pulse after last column accepted

Behaviour:
- Reset values: all outputs 0 except col_dist_sq = all ones; state = S_IDLE. Reset mid-sweep aborts the frame immediately with no frame_done.
- S_IDLE:
  - On start_frame: latch player_x/y into ray_x/ray_y.
  - Angle = player angle + HALF_FOV_DEG, taken mod 360.
  - col_idx = 0, busy = 1, go to S_LAUNCH.
- S_IDLE with no start_frame: start_frame is ignored in every other state.
- S_LAUNCH:
  - begin_calc = 1 for exactly one cycle.
  - Clear h_done, v_done and the wait counter.
  - Go to S_WAIT_HITS.
- S_WAIT_HITS:
  - On first cycle of h_end_calc while h_done = 0: capture h_wall_found/x/y and set h_done. Same rule for the vertical finder.
  - Both may arrive in the same cycle, and either may arrive first.
  - Leave when h_done && v_done, or when the counter reaches MAX_WAIT. A missing side is forced to found = 0.
- S_DIST:
  - Register dx^2 + dy^2 for each side.
  - dx, dy are 14-bit signed differences from ray_x/ray_y. Squares are unsigned 26-bit; sum is 27-bit, no overflow possible.
- S_SELECT:
  - Both found: smaller distance wins; tie goes to horizontal (side 0).
  - Only one found: that side wins.
  - Neither found: col_hit = 0, col_side = 0, col_dist_sq = all ones.
  - Load col_* outputs, go to S_OUTPUT.
- S_OUTPUT:
  - col_valid = 1; col_* held stable until col_ready is sampled high.
  - Transfer occurs on the cycle with col_valid && col_ready; col_valid deasserts the next cycle.
- S_ADVANCE:
  - If col_idx == NUM_COLS-1: pulse frame_done, clear busy, go to S_IDLE.
  - Otherwise: col_idx + 1, angle -= ANGLE_STEP_FRAC, go to S_LAUNCH.
- Angle arithmetic:
  - Angle held internally as int*1024 + frac (19 bits).
  - Subtract the step; if the result is negative, add 360*1024.
  - On start, if the sum is >= 360*1024, subtract 360*1024.
  - alpha_X/alpha_Y are the integer and fraction fields of this value.
- Throughput: minimum 5 cycles plus finder latency per column; alpha_X/Y stay stable from S_LAUNCH through S_WAIT_HITS.

Decomposition:
- Shared package raycast_pkg holds:
  - ANGLE_FULL_FIXED = 368640 (360*1024), FRAC_BITS = 10.
  - MAZE_MAX = 4096, SIDE_HORIZ = 0, SIDE_VERT = 1.
  - DIST_MISS = 27'h7FFFFFF.
- Sub-module ray_dist_sq: combinational squared distance, two instances, outputs registered in S_DIST.

Test Plan:
- Angle start: player (100,100), angle 90.0, start_frame, col_ready = 1 → col 0 launches with alpha_X = 120, alpha_Y = 0; col 1 with alpha_X = 119, alpha_Y = 640.
- Wrap: angle 10.0 → col 0 alpha = 40.0; col 159 alpha_X = 340, alpha_Y = 384. Angle 340.0 → col 0 alpha_X = 10.
- Select:
  - h hit (100,36), v hit (164,110) → col_side = 0, col_dist_sq = 4096.
  - Swap the two hits → col_side = 1, col_dist_sq = 4096.
  - h at distance 4196, v at 4196 → col_side = 0.
- Miss and timeout:
  - Both wall_found = 0 → col_hit = 0, col_dist_sq = 27'h7FFFFFF.
  - v_end_calc never asserted, MAX_WAIT = 15, h hit found → col_valid 18 cycles after begin_calc, col_side = 0.
- Backpressure: col_ready low for 10 cycles → col_* stable, no second begin_calc; frame_done fires once after 160 accepted columns.
- Reset and ignored start:
  - resetn low during col 37 → outputs return to reset values, no frame_done.
  - start_frame during a sweep → ignored.
